// File: rtl/rhs_stim_pkg.sv
// rhs_stim_pkg: shared types and constants for the RHS stimulation sequencers
package rhs_stim_pkg;

    localparam int CHAN_W           = 5;
    localparam int TICK_DIV_DEFAULT = 2800;

    typedef enum logic [1:0] {
        STIM_ON        = 2'd0,
        STIM_OFF       = 2'd1,
        CHARGE_RECOVER = 2'd2
    } cmd_op_t;

    typedef enum logic [3:0] {
        IDLE,
        PH1,
        W1,
        PH2,
        W2,
        OFF,
        CR,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/rhs_stim_sequencer_tick_timer.sv
// rhs_tick_timer: tick prescaler plus tick down-counter; expire marks the cycle the last tick lands
module rhs_tick_timer #(
    parameter int TICK_DIV = 2800,
    parameter int W        = 16
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         load,
    input  logic [W-1:0] ticks,
    input  logic         count,
    output logic         expire
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [W-1:0]  remain;
    logic          tick;

    assign tick   = count && (presc == PW'(TICK_DIV - 1));
    assign expire = tick && (remain == W'(1));

    // Load restarts the prescaler so every wait is an exact multiple of TICK_DIV cycles
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            presc  <= '0;
            remain <= '0;
        end else if (load) begin
            presc  <= '0;
            remain <= ticks;
        end else if (count) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && remain != '0)
                remain <= remain - 1'b1;
        end
    end

endmodule

// File: rtl/rhs_stim_sequencer.sv
// rhs_stim_sequencer: biphasic pulse-train sequencer issuing stim commands over valid/ready
// Optional charge-recovery step after each pulse is built when RHS_STIM_CHARGE_RECOVERY_EN is defined
module rhs_stim_sequencer
    import rhs_stim_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CNT_W    = 16
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    ,
    parameter int CR_TICKS = 2
`endif
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAN_W-1:0] stim_pos_chan,
    input  logic [CHAN_W-1:0] stim_neg_chan,
    input  logic              monopolar,
    input  logic [CNT_W-1:0]  pulse_width,
    input  logic [CNT_W-1:0]  intrapulse_delay,
    input  logic [CNT_W-1:0]  num_pulse,
    input  logic              infinite,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic              cmd_phase,
    output logic [CHAN_W-1:0] cmd_pos_chan,
    output logic [CHAN_W-1:0] cmd_neg_chan,
    output logic              cmd_bipolar,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  pulse_cnt
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  pw_l, dly_l, num_l, pw_ticks, tmr_ticks;
    logic              inf_l, abort_pend, more, more_now, hs;
    logic              tmr_load, tmr_count, tmr_expire;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    logic              cr_wait;
`endif

    assign hs       = cmd_valid & cmd_ready;
    assign pw_ticks = (pw_l == '0) ? CNT_W'(1) : pw_l;
    assign more_now = inf_l | (pulse_cnt < num_l);

    rhs_tick_timer #(.TICK_DIV(TICK_DIV), .W(CNT_W)) u_timer (
        .aclk   (aclk),
        .areset (areset),
        .load   (tmr_load),
        .ticks  (tmr_ticks),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Config latch, pulse counter, abort tracking and sticky status
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_pos_chan <= '0;
            cmd_neg_chan <= '0;
            cmd_bipolar  <= 1'b0;
            pw_l         <= '0;
            dly_l        <= '0;
            num_l        <= '0;
            inf_l        <= 1'b0;
            pulse_cnt    <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            abort_pend   <= 1'b0;
            more         <= 1'b0;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
            cr_wait      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                cmd_pos_chan <= stim_pos_chan;
                cmd_neg_chan <= stim_neg_chan;
                cmd_bipolar  <= ~monopolar;
                pw_l         <= pulse_width;
                dly_l        <= intrapulse_delay;
                num_l        <= num_pulse;
                inf_l        <= infinite;
                pulse_cnt    <= '0;
                done         <= 1'b0;
                aborted      <= 1'b0;
                abort_pend   <= 1'b0;
            end
            if (abort && busy)
                abort_pend <= 1'b1;
            if (state == OFF && hs) begin
                pulse_cnt <= (&pulse_cnt) ? pulse_cnt : pulse_cnt + 1'b1;
                more      <= more_now;
            end
            if (state == DONE) begin
                done    <= 1'b1;
                aborted <= abort_pend;
            end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
            cr_wait <= (state == CR) && (state_nx == CR) && (cr_wait || hs);
`endif
        end
    end

    // Next-state logic; wait timers are loaded on the transition into each wait
    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_ticks = pw_ticks;
        case (state)
            IDLE: if (start) state_nx = PH1;
            PH1: begin
                if (abort)
                    state_nx = OFF;
                else if (hs) begin
                    state_nx = W1;
                    tmr_load = 1'b1;
                end
            end
            W1: if (abort) state_nx = OFF; else if (tmr_expire) state_nx = PH2;
            PH2: begin
                if (abort)
                    state_nx = OFF;
                else if (hs) begin
                    state_nx = W2;
                    tmr_load = 1'b1;
                end
            end
            W2: if (abort || tmr_expire) state_nx = OFF;
            OFF: begin
                if (hs) begin
                    if (abort_pend || abort)
                        state_nx = DONE;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
                    else
                        state_nx = CR;
`else
                    else if (dly_l != '0) begin
                        state_nx  = GAP;
                        tmr_load  = 1'b1;
                        tmr_ticks = dly_l;
                    end else
                        state_nx = more_now ? PH1 : DONE;
`endif
                end
            end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
            CR: begin
                if (!cr_wait) begin
                    if (hs && (abort_pend || abort))
                        state_nx = DONE;
                    else if (hs) begin
                        tmr_load  = 1'b1;
                        tmr_ticks = CNT_W'(CR_TICKS);
                    end
                end else if (abort)
                    state_nx = DONE;
                else if (tmr_expire) begin
                    if (dly_l != '0) begin
                        state_nx  = GAP;
                        tmr_load  = 1'b1;
                        tmr_ticks = dly_l;
                    end else
                        state_nx = more ? PH1 : DONE;
                end
            end
`endif
            GAP: if (abort) state_nx = DONE; else if (tmr_expire) state_nx = more ? PH1 : DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command and status outputs decoded from the current state
    always_comb begin
        cmd_valid = state inside {PH1, PH2, OFF};
        cmd_op    = (state == OFF) ? STIM_OFF : STIM_ON;
        cmd_phase = (state == PH2);
        busy      = (state != IDLE) && (state != DONE);
        tmr_count = state inside {W1, W2, GAP};
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
        cmd_valid = cmd_valid | (state == CR && !cr_wait);
        cmd_op    = (state == CR) ? CHARGE_RECOVER : cmd_op;
        tmr_count = tmr_count | (state == CR && cr_wait);
`endif
    end

endmodule

// File: doc/rhs_stim_sequencer.md
Name: rhs_stim_sequencer

Overview:
- Sequences biphasic stimulation pulse trains for the RHS headstage by issuing timed stim commands to the RHS SPI command engine over a valid/ready handshake.
- Configuration comes from the AXI-Lite register file: stim channel at 0x10, pulse width at 0x14, intrapulse delay at 0x18, num pulse at 0x1C. Start and abort come from control register 0x0, where bit 3 is stim enable.
- Timing base is a 50 us tick derived from aclk.
- Status feeds control-register bit 16 (done).

Parameters:
- TICK_DIV, 2800, aclk cycles per 50 us tick (56 MHz aclk).
- CNT_W, 16, width of pulse width, delay and pulse-count fields.
- CR_TICKS, 2, charge-recovery duration in ticks (used only with the optional feature).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- start  in  1  single-cycle start pulse
- abort  in  1  single-cycle abort pulse
- stim_pos_chan  in  5  positive channel (reg 0x10 [4:0])
- stim_neg_chan  in  5  negative channel (reg 0x10 [9:5])
- monopolar  in  1  1 = ignore neg channel (reg 0x10 [10])
- pulse_width  in  CNT_W  phase width in ticks
- intrapulse_delay  in  CNT_W  inter-pulse gap in ticks
- num_pulse  in  CNT_W  number of pulses = num_pulse + 1
- infinite  in  1  repeat until abort (reg 0x1C [10])
- cmd_valid  out  1  command request
- cmd_ready  in  1  command engine accepts
- cmd_op  out  2  STIM_ON=0, STIM_OFF=1, CHARGE_RECOVER=2
- cmd_phase  out  1  0 = cathodic-first phase, 1 = anodic phase
- cmd_pos_chan  out  5  latched positive channel
- cmd_neg_chan  out  5  latched negative channel
- cmd_bipolar  out  1  latched ~monopolar
- busy  out  1  sequence active
- done  out  1  sticky completion flag
- aborted  out  1  sticky, set when the last sequence ended by abort
- pulse_cnt  out  CNT_W  pulses completed in current or last run

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-sequence drops cmd_valid immediately; no STIM_OFF is issued (the SPI engine is reset by the same areset).
- IDLE: on start, latch all config inputs, clear done, aborted and pulse_cnt, and go to PH1. busy=1 from the cycle after start.
- start while busy is ignored. Config inputs are sampled only at start.
- ISSUE states (PH1, PH2, OFF, CR):
  - Assert cmd_valid with stable cmd_* fields until a cycle with cmd_valid & cmd_ready.
  - cmd_* fields must not change while valid and not ready.
  - Handshake completes in that cycle. The next state is entered the following cycle.
- PH1: cmd_op=STIM_ON, cmd_phase=0, then W1.
- W1: wait pw*TICK_DIV cycles, where pw = max(pulse_width, 1). Then go to PH2.
- PH2: cmd_op=STIM_ON, cmd_phase=1, then W2.
- W2: same duration as W1. Then go to OFF.
- OFF: cmd_op=STIM_OFF. Increment pulse_cnt on the handshake. Then go to GAP, or to CR when the optional feature is enabled.
- GAP: wait intrapulse_delay*TICK_DIV cycles; delay 0 skips GAP.
- After GAP:
  - If infinite, or pulse_cnt <= num_pulse, go to PH1.
  - Otherwise go to DONE.
- DONE: set done=1, busy=0, return to IDLE in one cycle. done stays set until the next start.
- Timer:
  - Restarts in the cycle the wait state is entered.
  - The prescaler emits a tick every TICK_DIV cycles and a down-counter counts ticks.
  - The wait ends in the cycle the final tick is counted. No drift across phases.
- Abort:
  - In W1, W2, PH1 or PH2 (output on or pending): go to OFF, then to DONE with aborted=1 and done=1.
  - A PH1/PH2 command still pending handshake is withdrawn; this is the only legal case of cmd_valid dropping before ready.
  - In GAP or CR: go straight to DONE with aborted=1.
  - In OFF: finish OFF, then DONE with aborted=1.
  - Abort in IDLE is ignored.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- pulse_cnt saturates at all-ones in infinite mode.

Optional Feature:
- Macro: RHS_STIM_CHARGE_RECOVERY_EN.
- Defined: after each OFF handshake, issue cmd_op=CHARGE_RECOVER, wait CR_TICKS ticks, then go to GAP. Total gap = CR_TICKS + intrapulse_delay ticks.
- Not defined: the CR state and CR_TICKS logic are absent, and cmd_op never equals 2.

Decomposition:
- Package rhs_stim_pkg holds:
  - cmd_op_t enum (STIM_ON, STIM_OFF, CHARGE_RECOVER)
  - state_t enum (IDLE, PH1, W1, PH2, W2, OFF, CR, GAP, DONE)
  - CHAN_W=5 and TICK_DIV_DEFAULT=2800
- Sub-module rhs_tick_timer: prescaler plus tick down-counter, with load, count and expire signals. It is reused by the zcheck sequencer.

Test Plan:
- TICK_DIV=4, pw=1, delay=16, num=1, cmd_ready=1, bipolar chans 17/18.
  - Commands are ON/0, ON/1, OFF, ON/0, ON/1, OFF.
  - 4 cycles between ON/0 and ON/1; 64 cycles between OFF and the next ON/0.
  - Then done=1, pulse_cnt=2, busy=0.
- Same config, cmd_ready held low 5 cycles per command:
  - cmd_* stable throughout.
  - Wait phases start the cycle after ready.
  - Total duration grows by 30 cycles.
- pw=8, abort at 10 cycles into W1: next command is OFF; then done=1, aborted=1, pulse_cnt=1.
- infinite=1, delay=0: PH1 follows the OFF handshake directly; runs 50 pulses; abort in W2 gives OFF then aborted=1.
- start pulsed again while busy and areset asserted mid-W2: second start has no effect; after reset all outputs are 0 with no further cmd_valid.
- With RHS_STIM_CHARGE_RECOVERY_EN, CR_TICKS=2, TICK_DIV=4: CHARGE_RECOVER follows each OFF; 8 cycles pass before GAP starts.
